// File: rtl/signal_debounce.sv
// Debounces an asynchronous, glitchy input line: two-flop synchronizer, a
// four-state qualify FSM, a rising-edge trigger pulse and a saturating event counter.
module signal_debounce #(
  parameter int STABLE_CNT = 8,
  parameter int DIM        = 6,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             raw_in,
  input  logic             enable,
  input  logic             clear_count,
  output logic             level_out,
  output logic             trigger_out,
  output logic [CNT_W-1:0] event_count
);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  localparam logic [DIM:0] CNT_LAST = (DIM+1)'(STABLE_CNT - 1);
  localparam logic [DIM:0] CNT_ONE  = (DIM+1)'(1);

  logic             s1_q, s2_q;
  state_t           state_q, state_d;
  logic [DIM:0]     cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             trig_q, trig_d;
  logic [CNT_W-1:0] ev_q, ev_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_in;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d = LOW;
    cnt_d   = '0;
    trig_d  = 1'b0;
    if (enable) begin
      case (state_q)
        LOW: begin
          if (s2_q) begin
            state_d = RISE_CHK;
            cnt_d   = CNT_ONE;
          end
        end
        RISE_CHK: begin
          if (!s2_q) begin
            state_d = LOW;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HIGH;
            trig_d  = 1'b1;
          end else begin
            state_d = RISE_CHK;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        HIGH: begin
          state_d = HIGH;
          if (!s2_q) begin
            state_d = FALL_CHK;
            cnt_d   = CNT_ONE;
          end
        end
        FALL_CHK: begin
          if (s2_q) begin
            state_d = HIGH;
          end else if (cnt_q == CNT_LAST) begin
            state_d = LOW;
          end else begin
            state_d = FALL_CHK;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = LOW;
        end
      endcase
    end
    level_d = (state_d == HIGH) || (state_d == FALL_CHK);
  end

  // Counter tracks the registered trigger: it bumps on the same edge the pulse appears.
  always_comb begin
    ev_d = ev_q;
    if (clear_count) begin
      ev_d = trig_d ? CNT_W'(1) : '0;
    end else if (trig_d) begin
      ev_d = sat_inc(ev_q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      trig_q  <= 1'b0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      trig_q  <= trig_d;
      ev_q    <= ev_d;
    end
  end

  assign level_out   = level_q;
  assign trigger_out = trig_q;
  assign event_count = ev_q;

endmodule

// File: tb/tb_signal_debounce.sv
// Directed bench for signal_debounce with STABLE_CNT=4 and a 2-bit event counter.
module tb_signal_debounce;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       raw_in = 1'b0;
  logic       enable = 1'b1;
  logic       clear_count = 1'b0;
  logic       level_out;
  logic       trigger_out;
  logic [1:0] event_count;

  int errors = 0;
  int checks = 0;

  signal_debounce #(.STABLE_CNT(4), .DIM(6), .CNT_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .raw_in      (raw_in),
    .enable      (enable),
    .clear_count (clear_count),
    .level_out   (level_out),
    .trigger_out (trigger_out),
    .event_count (event_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns the line to LOW, then raises raw_in and follows the qualify window.
  task automatic pulse(input string tag, input logic [1:0] exp_cnt, input logic clr_at_trig);
    raw_in = 1'b0;
    repeat (7) tick();
    chk({tag, "_low"}, level_out, 0);
    raw_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) clear_count = clr_at_trig;
      tick();
      clear_count = 1'b0;
      chk({tag, "_trig"}, trigger_out, (k == 5));
    end
    chk({tag, "_cnt"}, event_count, exp_cnt);
  endtask

  initial begin
    // Asynchronous reset without clock edge dependency
    #2 reset = 1'b0;
    #1;
    chk("rst_level", level_out, 0);
    chk("rst_trig", trigger_out, 0);
    chk("rst_cnt", event_count, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();

    // Clean rise: trigger after the 5th edge, level stays high
    raw_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rise_trig", trigger_out, (k == 5));
      chk("rise_level", level_out, (k >= 5));
    end
    chk("rise_cnt", event_count, 1);

    // Short low glitch while HIGH is rejected
    raw_in = 1'b0;
    tick(); tick();
    raw_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("fglitch_level", level_out, 1);
      chk("fglitch_trig", trigger_out, 0);
    end

    // Held low: level drops after 5 edges, never a trigger
    raw_in = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("fall_level", level_out, (k < 5));
      chk("fall_trig", trigger_out, 0);
    end
    chk("fall_cnt", event_count, 1);

    // 3-cycle high glitch is rejected
    raw_in = 1'b1;
    tick(); tick(); tick();
    raw_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rglitch_trig", trigger_out, 0);
      chk("rglitch_level", level_out, 0);
    end
    chk("rglitch_cnt", event_count, 1);

    // Enable drop in HIGH, then re-enable with the line still high
    raw_in = 1'b1;
    repeat (6) tick();
    chk("en_pre_level", level_out, 1);
    chk("en_pre_cnt", event_count, 2);
    enable = 1'b0;
    tick();
    chk("en_off_level", level_out, 0);
    chk("en_off_trig", trigger_out, 0);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("en_re_trig", trigger_out, (k == 3));
    end
    chk("en_re_cnt", event_count, 3);

    // Saturation at all-ones
    pulse("sat4", 2'd3, 1'b0);
    pulse("sat5", 2'd3, 1'b0);

    // Plain clear, then clear coinciding with a trigger
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    chk("clr_cnt", event_count, 0);
    pulse("post_clr", 2'd1, 1'b0);
    pulse("clr_trig", 2'd1, 1'b1);

    // Reset while in RISE_CHK acts without a clock edge
    raw_in = 1'b0;
    repeat (7) tick();
    raw_in = 1'b1;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    chk("midrst_level", level_out, 0);
    chk("midrst_trig", trigger_out, 0);
    chk("midrst_cnt", event_count, 0);
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("rel_trig", trigger_out, (k == 5));
      chk("rel_level", level_out, (k >= 5));
    end
    chk("rel_cnt", event_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/signal_debounce.md
SIGNAL_DEBOUNCE -- requirements
Module: signal_debounce

Interface
REQ-001 Parameter STABLE_CNT, default 8: consecutive synchronized samples needed to accept a level change; legal range 2 to 2^(DIM+1)-1.
REQ-002 Parameter DIM, default 6: debounce counter is DIM+1 bits wide.
REQ-003 Parameter CNT_W, default 8: event counter width.
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port raw_in, input, 1 bit: asynchronous sensor/comparator line; may glitch.
REQ-007 Port enable, input, 1 bit: synchronous; 1 = detection active.
REQ-008 Port clear_count, input, 1 bit: synchronous clear of event_count.
REQ-009 Port level_out, output, 1 bit: debounced level, registered.
REQ-010 Port trigger_out, output, 1 bit: one-cycle registered pulse on each accepted rising edge; drives the signal_in of the downstream pulse-expander stage.
REQ-011 Port event_count, output, CNT_W bits: count of accepted rising edges, registered.

Function
REQ-012 raw_in SHALL pass through a two-flop synchronizer (s1, s2); only s2 is used by the FSM.
REQ-013 The FSM SHALL have four states: LOW, RISE_CHK, HIGH, FALL_CHK; a counter cnt (DIM+1 bits) tracks consecutive qualifying samples.
REQ-014 LOW: enable=1 and s2=1 -> RISE_CHK with cnt=1; otherwise stay in LOW with cnt=0.
REQ-015 RISE_CHK: s2=0 -> LOW with cnt=0 (glitch rejected, no trigger); s2=1 and cnt=STABLE_CNT-1 -> HIGH with cnt=0; otherwise cnt+1.
REQ-016 On the RISE_CHK->HIGH transition, trigger_out SHALL be 1 for exactly that one following cycle; it is 0 in every other cycle.
REQ-017 HIGH: s2=0 -> FALL_CHK with cnt=1; otherwise stay.
REQ-018 FALL_CHK: s2=1 -> HIGH with cnt=0 (no trigger); s2=0 and cnt=STABLE_CNT-1 -> LOW with cnt=0; otherwise cnt+1.
REQ-019 level_out SHALL be 1 in HIGH and FALL_CHK, and 0 in LOW and RISE_CHK; it is registered alongside the state.
REQ-020 Latency: with raw_in rising before edge e0 and held, trigger_out and level_out SHALL rise after edge e(STABLE_CNT+1).
REQ-021 enable=0 in any state SHALL force state LOW, cnt=0, level_out=0 and trigger_out=0 on the next edge; the synchronizer keeps running.
REQ-022 A falling edge SHALL never produce trigger_out.
REQ-023 event_count SHALL increment by 1 in the cycle trigger_out is asserted, and saturate at all-ones.
REQ-024 clear_count=1 SHALL set event_count to 0 on the next edge; if a trigger occurs in the same cycle, event_count SHALL become 1.
REQ-025 An unreachable state encoding SHALL recover to LOW on the next edge with all outputs 0.

Reset
REQ-026 reset=0 SHALL immediately and asynchronously force s1=s2=0, state LOW, cnt=0, level_out=0, trigger_out=0 and event_count=0.
REQ-027 Reset applied mid-operation (any state) SHALL abort the operation.
REQ-028 After reset is released with raw_in held high, the block SHALL requalify over the full STABLE_CNT samples and then issue one trigger.
REQ-029 Reset release SHALL take effect at the first rising edge of clock after reset returns to 1.

Verification
REQ-030 STABLE_CNT=4, enable=1, raw_in 0->1 held -> trigger_out high for exactly one cycle after the 5th edge; level_out=1 from then on; event_count=1.
REQ-031 raw_in high for 3 cycles then low (STABLE_CNT=4) -> no trigger_out; level_out stays 0; event_count stays 0.
REQ-032 In HIGH, raw_in low for 2 cycles then high -> level_out stays 1; no trigger. Then raw_in low held -> level_out=0 after 5 edges; no trigger.
REQ-033 CNT_W=2 with 5 accepted pulses -> event_count reads 1,2,3,3,3. clear_count asserted in the same cycle as a trigger -> event_count=1.
REQ-034 enable dropped while in HIGH -> level_out=0 on the next edge. Then enable=1 with raw_in still high -> new trigger after 4 samples.
REQ-035 reset asserted in RISE_CHK -> all outputs 0 without waiting for a clock. After release with raw_in high -> one trigger after the 5th edge.
